// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - AXI4-Lite configuration widths and request/response bundle types
package axil_pkg;

  localparam int AXI4L_CONF_ADDR_WIDTH = 32;
  localparam int AXI4L_CONF_DATA_WIDTH = 32;
  localparam int AXI4L_CONF_STRB_WIDTH = AXI4L_CONF_DATA_WIDTH / 8;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic                             aw_valid;
    logic [AXI4L_CONF_ADDR_WIDTH-1:0] aw_addr;
    logic [2:0]                       aw_prot;
    logic                             w_valid;
    logic [AXI4L_CONF_DATA_WIDTH-1:0] w_data;
    logic [AXI4L_CONF_STRB_WIDTH-1:0] w_strb;
    logic                             b_ready;
    logic                             ar_valid;
    logic [AXI4L_CONF_ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]                       ar_prot;
    logic                             r_ready;
  } axil_req_t;

  typedef struct packed {
    logic                             aw_ready;
    logic                             w_ready;
    logic                             b_valid;
    logic [1:0]                       b_resp;
    logic                             ar_ready;
    logic                             r_valid;
    logic [AXI4L_CONF_DATA_WIDTH-1:0] r_data;
    logic [1:0]                       r_resp;
  } axil_rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with a last-grant register
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_idx_i,
  output logic       gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    last_d = last_q;
    if (upd_i) begin
      last_d = upd_idx_i;
    end
  end

  // Reset to 1 so master 0 wins the very first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    gnt_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_o = ~last_q;
    end else if (req_i[1]) begin
      gnt_o = 1'b1;
    end
  end

endmodule

// File: rtl/axil_rr_arbiter.sv
// rtl/axil_rr_arbiter.sv - two-master AXI4-Lite arbiter, independent round-robin read and write paths
module axil_rr_arbiter
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI4L_CONF_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI4L_CONF_DATA_WIDTH
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axil_req_t m0_req_i,
  output axil_rsp_t m0_rsp_o,
  input  axil_req_t m1_req_i,
  output axil_rsp_t m1_rsp_o,
  output axil_req_t s_req_o,
  input  axil_rsp_t s_rsp_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_RESP} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  logic      rd_gnt_q, rd_gnt_d;
  logic      wr_gnt_q, wr_gnt_d;
  logic      aw_done_q, aw_done_d;
  logic      w_done_q, w_done_d;
  logic      rd_arb_gnt, wr_arb_gnt;
  logic      ar_hs, r_hs, aw_hs, w_hs, b_hs;

  axil_req_t rd_sel, wr_sel;
  axil_rsp_t rd_rsp, wr_rsp;

  logic [ADDR_WIDTH-1:0] ar_addr, aw_addr;
  logic [DATA_WIDTH-1:0] w_data, r_data;
  logic [STRB_WIDTH-1:0] w_strb;

  assign rd_sel = rd_gnt_q ? m1_req_i : m0_req_i;
  assign wr_sel = wr_gnt_q ? m1_req_i : m0_req_i;

  rr_arb2 u_rd_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     ({m1_req_i.ar_valid, m0_req_i.ar_valid}),
    .upd_i     (r_hs),
    .upd_idx_i (rd_gnt_q),
    .gnt_o     (rd_arb_gnt)
  );

  rr_arb2 u_wr_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     ({m1_req_i.aw_valid, m0_req_i.aw_valid}),
    .upd_i     (b_hs),
    .upd_idx_i (wr_gnt_q),
    .gnt_o     (wr_arb_gnt)
  );

  assign ar_hs = (rd_state_q == RD_ADDR) && rd_sel.ar_valid && s_rsp_i.ar_ready;
  assign r_hs  = (rd_state_q == RD_DATA) && s_rsp_i.r_valid && rd_sel.r_ready;
  assign aw_hs = (wr_state_q == WR_REQ) && !aw_done_q && wr_sel.aw_valid && s_rsp_i.aw_ready;
  assign w_hs  = (wr_state_q == WR_REQ) && !w_done_q && wr_sel.w_valid && s_rsp_i.w_ready;
  assign b_hs  = (wr_state_q == WR_RESP) && s_rsp_i.b_valid && wr_sel.b_ready;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (m0_req_i.ar_valid || m1_req_i.ar_valid) begin
          rd_gnt_d   = rd_arb_gnt;
          rd_state_d = RD_ADDR;
        end
      end
      RD_ADDR: if (ar_hs) rd_state_d = RD_DATA;
      RD_DATA: if (r_hs) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (m0_req_i.aw_valid || m1_req_i.aw_valid) begin
          wr_gnt_d   = wr_arb_gnt;
          wr_state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) begin
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      rd_gnt_q   <= 1'b0;
      wr_gnt_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  assign ar_addr = rd_sel.ar_addr;
  assign aw_addr = wr_sel.aw_addr;
  assign w_data  = wr_sel.w_data;
  assign w_strb  = wr_sel.w_strb;
  assign r_data  = s_rsp_i.r_data;

  // Payloads always follow the current grantee; only valids/readies are gated,
  // and reset forces those low combinationally in the same cycle.
  always_comb begin
    s_req_o         = '0;
    rd_rsp          = '0;
    wr_rsp          = '0;
    s_req_o.ar_addr = ar_addr;
    s_req_o.ar_prot = rd_sel.ar_prot;
    s_req_o.aw_addr = aw_addr;
    s_req_o.aw_prot = wr_sel.aw_prot;
    s_req_o.w_data  = w_data;
    s_req_o.w_strb  = w_strb;
    rd_rsp.r_data   = r_data;
    rd_rsp.r_resp   = s_rsp_i.r_resp;
    wr_rsp.b_resp   = s_rsp_i.b_resp;
    if (!rst_i) begin
      case (rd_state_q)
        RD_ADDR: begin
          s_req_o.ar_valid = rd_sel.ar_valid;
          rd_rsp.ar_ready  = s_rsp_i.ar_ready;
        end
        RD_DATA: begin
          s_req_o.r_ready = rd_sel.r_ready;
          rd_rsp.r_valid  = s_rsp_i.r_valid;
        end
        default: ;
      endcase
      case (wr_state_q)
        WR_REQ: begin
          s_req_o.aw_valid = wr_sel.aw_valid & ~aw_done_q;
          s_req_o.w_valid  = wr_sel.w_valid & ~w_done_q;
          wr_rsp.aw_ready  = s_rsp_i.aw_ready & ~aw_done_q;
          wr_rsp.w_ready   = s_rsp_i.w_ready & ~w_done_q;
        end
        WR_RESP: begin
          s_req_o.b_ready = wr_sel.b_ready;
          wr_rsp.b_valid  = s_rsp_i.b_valid;
        end
        default: ;
      endcase
    end
    m0_rsp_o = (rd_gnt_q ? axil_rsp_t'('0) : rd_rsp) | (wr_gnt_q ? axil_rsp_t'('0) : wr_rsp);
    m1_rsp_o = (rd_gnt_q ? rd_rsp : axil_rsp_t'('0)) | (wr_gnt_q ? wr_rsp : axil_rsp_t'('0));
  end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// tb/tb_axil_rr_arbiter.sv - directed self-checking bench for axil_rr_arbiter
module tb_axil_rr_arbiter;
  import axil_pkg::*;

  logic      clk;
  logic      rst;
  axil_req_t m0_req, m1_req, s_req;
  axil_rsp_t m0_rsp, m1_rsp, s_rsp;
  int        tests;
  int        fails;

  axil_rr_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .m0_req_i (m0_req),
    .m0_rsp_o (m0_rsp),
    .m1_req_i (m1_req),
    .m1_rsp_o (m1_rsp),
    .s_req_o  (s_req),
    .s_rsp_i  (s_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    m0_req = '0;
    m1_req = '0;
    s_rsp = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Caller sets the requesting master(s) at the drive point; returns at a drive point in idle.
  task automatic serve_read(input logic exp_m, input logic [31:0] exp_addr,
                            input logic [31:0] rdata, input logic [1:0] rresp, output int lat);
    logic g_rdy, o_rdy, g_rv, o_rv;
    logic [31:0] g_data;
    logic [1:0] g_resp;
    #1;
    lat = 0;
    while (s_req.ar_valid !== 1'b1 && lat < 5) begin
      @(posedge clk);
      #2;
      lat++;
    end
    tests++;
    if (s_req.ar_valid !== 1'b1) begin
      fails++;
      $display("FAIL rd_arvalid_timeout: got %b expected 1", s_req.ar_valid);
    end
    tests++;
    if (s_req.ar_addr !== exp_addr) begin
      fails++;
      $display("FAIL rd_araddr: got %h expected %h", s_req.ar_addr, exp_addr);
    end
    s_rsp.ar_ready = 1'b1;
    #1;
    g_rdy = exp_m ? m1_rsp.ar_ready : m0_rsp.ar_ready;
    o_rdy = exp_m ? m0_rsp.ar_ready : m1_rsp.ar_ready;
    tests++;
    if ({g_rdy, o_rdy} !== 2'b10) begin
      fails++;
      $display("FAIL rd_arready_route m%0d: got %b expected 10", exp_m, {g_rdy, o_rdy});
    end
    tick();
    s_rsp.ar_ready = 1'b0;
    if (exp_m) m1_req.ar_valid = 1'b0;
    else m0_req.ar_valid = 1'b0;
    s_rsp.r_valid = 1'b1;
    s_rsp.r_data = rdata;
    s_rsp.r_resp = rresp;
    m0_req.r_ready = 1'b1;
    m1_req.r_ready = 1'b1;
    #1;
    g_rv   = exp_m ? m1_rsp.r_valid : m0_rsp.r_valid;
    o_rv   = exp_m ? m0_rsp.r_valid : m1_rsp.r_valid;
    g_data = exp_m ? m1_rsp.r_data : m0_rsp.r_data;
    g_resp = exp_m ? m1_rsp.r_resp : m0_rsp.r_resp;
    tests++;
    if ({g_rv, o_rv} !== 2'b10) begin
      fails++;
      $display("FAIL rd_rvalid_route m%0d: got %b expected 10", exp_m, {g_rv, o_rv});
    end
    tests++;
    if (g_data !== rdata || g_resp !== rresp) begin
      fails++;
      $display("FAIL rd_rdata m%0d: got %h/%b expected %h/%b", exp_m, g_data, g_resp, rdata, rresp);
    end
    tick();
    s_rsp.r_valid = 1'b0;
    m0_req.r_ready = 1'b0;
    m1_req.r_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_req = '0;
    m1_req = '0;
    m0_req.ar_valid = 1'b1;
    m0_req.aw_valid = 1'b1;
    m1_req.w_valid = 1'b1;
    m1_req.r_ready = 1'b1;
    m1_req.b_ready = 1'b1;
    s_rsp = '0;
    s_rsp.aw_ready = 1'b1;
    s_rsp.w_ready = 1'b1;
    s_rsp.ar_ready = 1'b1;
    s_rsp.r_valid = 1'b1;
    s_rsp.b_valid = 1'b1;
    tick();
    tick();
    #1;
    tests++;
    if ({s_req.aw_valid, s_req.w_valid, s_req.ar_valid, s_req.r_ready, s_req.b_ready} !== 5'b0) begin
      fails++;
      $display("FAIL reset_s_side: got %b expected 00000",
               {s_req.aw_valid, s_req.w_valid, s_req.ar_valid, s_req.r_ready, s_req.b_ready});
    end
    tests++;
    if ({m0_rsp.aw_ready, m0_rsp.w_ready, m0_rsp.ar_ready, m0_rsp.r_valid, m0_rsp.b_valid} !== 5'b0) begin
      fails++;
      $display("FAIL reset_m0_side: got %b expected 00000",
               {m0_rsp.aw_ready, m0_rsp.w_ready, m0_rsp.ar_ready, m0_rsp.r_valid, m0_rsp.b_valid});
    end
    tests++;
    if ({m1_rsp.aw_ready, m1_rsp.w_ready, m1_rsp.ar_ready, m1_rsp.r_valid, m1_rsp.b_valid} !== 5'b0) begin
      fails++;
      $display("FAIL reset_m1_side: got %b expected 00000",
               {m1_rsp.aw_ready, m1_rsp.w_ready, m1_rsp.ar_ready, m1_rsp.r_valid, m1_rsp.b_valid});
    end
    rst = 1'b0;
    m0_req = '0;
    m1_req = '0;
    m1_req.r_ready = 1'b1;
    m1_req.b_ready = 1'b1;
    m0_req.w_valid = 1'b1;
    tick();
    #1;
    tests++;
    if ({s_req.aw_valid, s_req.w_valid, s_req.r_ready, s_req.b_ready, m0_rsp.r_valid, m1_rsp.r_valid,
         m0_rsp.b_valid, m1_rsp.b_valid, m0_rsp.w_ready} !== 9'b0) begin
      fails++;
      $display("FAIL idle_masking: got %b expected 0", {s_req.aw_valid, s_req.w_valid, s_req.r_ready,
               s_req.b_ready, m0_rsp.r_valid, m1_rsp.r_valid, m0_rsp.b_valid, m1_rsp.b_valid, m0_rsp.w_ready});
    end
    m0_req = '0;
    m1_req = '0;
    s_rsp = '0;
    tick();
  endtask

  task automatic test_single_read();
    int lat;
    m0_req.ar_valid = 1'b1;
    m0_req.ar_addr = 32'h3000_0000;
    serve_read(1'b0, 32'h3000_0000, 32'hDEAD_BEEF, AXIL_RESP_OKAY, lat);
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL single_read_latency: got %0d expected 1", lat);
    end
  endtask

  task automatic test_tie();
    int lat;
    apply_reset();
    m0_req.ar_valid = 1'b1;
    m0_req.ar_addr = 32'h3000_0000;
    m1_req.ar_valid = 1'b1;
    m1_req.ar_addr = 32'h3000_0004;
    serve_read(1'b0, 32'h3000_0000, 32'h1111_0000, AXIL_RESP_OKAY, lat);
    m0_req.ar_valid = 1'b1;
    m0_req.ar_addr = 32'h3000_0008;
    serve_read(1'b1, 32'h3000_0004, 32'h2222_0004, AXIL_RESP_OKAY, lat);
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL tie_second_latency: got %0d expected 1", lat);
    end
    serve_read(1'b0, 32'h3000_0008, 32'h3333_0008, AXIL_RESP_OKAY, lat);
  endtask

  task automatic test_write_delayed_w();
    m1_req.aw_valid = 1'b1;
    m1_req.aw_addr = 32'h3000_0010;
    m1_req.b_ready = 1'b1;
    #1;
    tests++;
    if (s_req.aw_valid !== 1'b0) begin
      fails++;
      $display("FAIL wr_idle_awvalid: got %b expected 0", s_req.aw_valid);
    end
    tick();
    s_rsp.aw_ready = 1'b1;
    s_rsp.w_ready = 1'b1;
    #1;
    tests++;
    if ({s_req.aw_valid, m1_rsp.aw_ready, m0_rsp.aw_ready, s_req.w_valid, s_req.b_ready} !== 5'b11000) begin
      fails++;
      $display("FAIL wr_aw_phase: got %b expected 11000",
               {s_req.aw_valid, m1_rsp.aw_ready, m0_rsp.aw_ready, s_req.w_valid, s_req.b_ready});
    end
    tests++;
    if (s_req.aw_addr !== 32'h3000_0010) begin
      fails++;
      $display("FAIL wr_awaddr: got %h expected 30000010", s_req.aw_addr);
    end
    tick();
    #1;
    tests++;
    if ({s_req.aw_valid, m1_rsp.aw_ready, s_req.b_ready} !== 3'b000) begin
      fails++;
      $display("FAIL wr_aw_masked: got %b expected 000", {s_req.aw_valid, m1_rsp.aw_ready, s_req.b_ready});
    end
    m1_req.aw_valid = 1'b0;
    tick();
    m1_req.w_valid = 1'b1;
    m1_req.w_data = 32'h1234_5678;
    m1_req.w_strb = 4'hF;
    #1;
    tests++;
    if ({s_req.w_valid, m1_rsp.w_ready, s_req.b_ready} !== 3'b110 ||
        s_req.w_data !== 32'h1234_5678 || s_req.w_strb !== 4'hF) begin
      fails++;
      $display("FAIL wr_w_phase: got %b %h %h expected 110 12345678 f",
               {s_req.w_valid, m1_rsp.w_ready, s_req.b_ready}, s_req.w_data, s_req.w_strb);
    end
    tick();
    m1_req.w_valid = 1'b0;
    s_rsp.aw_ready = 1'b0;
    s_rsp.w_ready = 1'b0;
    s_rsp.b_valid = 1'b1;
    s_rsp.b_resp = AXIL_RESP_OKAY;
    #1;
    tests++;
    if ({m1_rsp.b_valid, m0_rsp.b_valid, s_req.b_ready, s_req.w_valid} !== 4'b1010 ||
        m1_rsp.b_resp !== AXIL_RESP_OKAY) begin
      fails++;
      $display("FAIL wr_b_phase: got %b resp %b expected 1010 resp 00",
               {m1_rsp.b_valid, m0_rsp.b_valid, s_req.b_ready, s_req.w_valid}, m1_rsp.b_resp);
    end
    tick();
    #1;
    tests++;
    if (m1_rsp.b_valid !== 1'b0) begin
      fails++;
      $display("FAIL wr_back_idle: got %b expected 0", m1_rsp.b_valid);
    end
    s_rsp = '0;
    m1_req = '0;
    tick();
  endtask

  task automatic test_concurrent();
    m0_req.aw_valid = 1'b1;
    m0_req.aw_addr = 32'h3000_0020;
    m0_req.w_valid = 1'b1;
    m0_req.w_data = 32'hCAFE_F00D;
    m0_req.w_strb = 4'h3;
    m0_req.b_ready = 1'b1;
    m1_req.ar_valid = 1'b1;
    m1_req.ar_addr = 32'h3000_0030;
    m1_req.r_ready = 1'b1;
    tick();
    s_rsp.aw_ready = 1'b1;
    s_rsp.w_ready = 1'b1;
    s_rsp.ar_ready = 1'b1;
    #1;
    tests++;
    if ({s_req.aw_valid, s_req.w_valid, s_req.ar_valid} !== 3'b111 || s_req.aw_addr !== 32'h3000_0020 ||
        s_req.ar_addr !== 32'h3000_0030 || s_req.w_data !== 32'hCAFE_F00D || s_req.w_strb !== 4'h3) begin
      fails++;
      $display("FAIL conc_s_side: got %b %h %h %h expected 111 30000020 30000030 cafef00d",
               {s_req.aw_valid, s_req.w_valid, s_req.ar_valid}, s_req.aw_addr, s_req.ar_addr, s_req.w_data);
    end
    tests++;
    if ({m0_rsp.aw_ready, m0_rsp.w_ready, m1_rsp.ar_ready, m0_rsp.ar_ready, m1_rsp.aw_ready} !== 5'b11100) begin
      fails++;
      $display("FAIL conc_ready_route: got %b expected 11100",
               {m0_rsp.aw_ready, m0_rsp.w_ready, m1_rsp.ar_ready, m0_rsp.ar_ready, m1_rsp.aw_ready});
    end
    tick();
    m0_req.aw_valid = 1'b0;
    m0_req.w_valid = 1'b0;
    m1_req.ar_valid = 1'b0;
    s_rsp = '0;
    s_rsp.r_valid = 1'b1;
    s_rsp.r_data = 32'h0000_55AA;
    s_rsp.b_valid = 1'b1;
    #1;
    tests++;
    if ({m1_rsp.r_valid, m0_rsp.b_valid, m0_rsp.r_valid, m1_rsp.b_valid} !== 4'b1100 ||
        m1_rsp.r_data !== 32'h0000_55AA) begin
      fails++;
      $display("FAIL conc_resp_route: got %b %h expected 1100 000055aa",
               {m1_rsp.r_valid, m0_rsp.b_valid, m0_rsp.r_valid, m1_rsp.b_valid}, m1_rsp.r_data);
    end
    tick();
    s_rsp = '0;
    #1;
    tests++;
    if ({s_req.r_ready, s_req.b_ready} !== 2'b00) begin
      fails++;
      $display("FAIL conc_back_idle: got %b expected 00", {s_req.r_ready, s_req.b_ready});
    end
    m0_req = '0;
    m1_req = '0;
    tick();
  endtask

  task automatic test_slverr();
    int lat;
    m0_req.ar_valid = 1'b1;
    m0_req.ar_addr = 32'h3000_00F0;
    serve_read(1'b0, 32'h3000_00F0, 32'hBAD0_BAD0, AXIL_RESP_SLVERR, lat);
  endtask

  task automatic test_reset_mid_read();
    int lat;
    m0_req.ar_valid = 1'b1;
    m0_req.ar_addr = 32'h3000_0040;
    tick();
    s_rsp.ar_ready = 1'b1;
    tick();
    s_rsp.ar_ready = 1'b0;
    m0_req.ar_valid = 1'b0;
    m0_req.r_ready = 1'b1;
    #1;
    tests++;
    if (s_req.r_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_rd_data_state: got %b expected 1", s_req.r_ready);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({s_req.r_ready, s_req.ar_valid, m0_rsp.ar_ready, m0_rsp.r_valid} !== 4'b0000) begin
      fails++;
      $display("FAIL mid_rst_outputs: got %b expected 0000",
               {s_req.r_ready, s_req.ar_valid, m0_rsp.ar_ready, m0_rsp.r_valid});
    end
    tick();
    rst = 1'b0;
    s_rsp.r_valid = 1'b1;
    #1;
    tests++;
    if ({s_req.r_ready, m0_rsp.r_valid} !== 2'b00) begin
      fails++;
      $display("FAIL mid_rst_abandoned: got %b expected 00", {s_req.r_ready, m0_rsp.r_valid});
    end
    s_rsp = '0;
    m0_req = '0;
    tick();
    m1_req.ar_valid = 1'b1;
    m1_req.ar_addr = 32'h3000_0050;
    serve_read(1'b1, 32'h3000_0050, 32'h0BAD_F00D, AXIL_RESP_OKAY, lat);
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL post_rst_read_latency: got %0d expected 1", lat);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    m0_req = '0;
    m1_req = '0;
    s_rsp = '0;
    test_reset();
    test_single_read();
    test_tie();
    test_write_delayed_w();
    test_concurrent();
    test_slverr();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_rr_arbiter.md
AXIL_RR_ARBITER -- requirements
Module: axil_rr_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default AXI4L_CONF_ADDR_WIDTH (32): the AXI4-Lite address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default AXI4L_CONF_DATA_WIDTH (32): the AXI4-Lite data width; strobe width is DATA_WIDTH/8.
REQ-003 clk_i  in  1  the single clock; all logic is rising-edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 m0_req_i  in  axil_req_t  master 0 request (aw, w, ar valids and payloads; bready, rready).
REQ-006 m0_rsp_o  out  axil_rsp_t  master 0 response (awready, wready, arready; b, r valids and payloads).
REQ-007 m1_req_i  in  axil_req_t  master 1 request.
REQ-008 m1_rsp_o  out  axil_rsp_t  master 1 response.
REQ-009 s_req_o  out  axil_req_t  shared slave request.
REQ-010 s_rsp_i  in  axil_rsp_t  shared slave response.

Function
REQ-011 Read and write paths SHALL arbitrate independently and SHALL be able to run concurrently, with one outstanding transaction per path.
REQ-012 Read FSM states SHALL be RD_IDLE, RD_ADDR and RD_DATA.
REQ-013 In RD_IDLE, any master arvalid SHALL register a grant and move to RD_ADDR on the next edge; s arvalid rises no earlier than 1 cycle after the master arvalid.
REQ-014 In RD_ADDR, the granted ar payload and arvalid SHALL be forwarded to s, and s arready SHALL be routed combinationally to the granted master only; an ar handshake moves the FSM to RD_DATA.
REQ-015 In RD_DATA, s rvalid, rdata and rresp SHALL be routed unchanged to the granted master, and that master's rready to s; an r handshake SHALL return the FSM to RD_IDLE and update the read last-grant.
REQ-016 Write FSM states SHALL be WR_IDLE, WR_REQ and WR_RESP; only awvalid requests a grant, and a lone wvalid is ignored in WR_IDLE.
REQ-017 In WR_REQ, aw and w of the granted master SHALL be forwarded to s independently.
REQ-018 In WR_REQ, aw_done and w_done flags SHALL be set on their respective handshakes, and each channel's s valid SHALL be masked once its flag is set.
REQ-019 WR_REQ SHALL move to WR_WRESP-equivalent WR_RESP when both flags are set, including when both set in the same cycle.
REQ-020 In WR_RESP, b SHALL be routed to the granted master; a b handshake SHALL return the FSM to WR_IDLE, clear both flags and update the write last-grant.
REQ-021 On a tie, each path SHALL grant the master that was not its last grantee (round-robin); a single requester SHALL always be granted.
REQ-022 A grant SHALL be held until the response handshake, even if the master drops its valid.
REQ-023 A non-granted master SHALL see all readies and response valids at 0.
REQ-024 In any IDLE state, all s-side valids and readies SHALL be 0.
REQ-025 Payloads (addr, prot, data, strb, resp) SHALL pass through with no width change.

Reset
REQ-026 While rst_i is high, both FSMs SHALL be in IDLE, aw_done and w_done SHALL be 0, and both last-grant registers SHALL be 1 so that master 0 wins the first tie.
REQ-027 While rst_i is high, all valid and ready outputs on every port SHALL be 0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction without issuing a response; the slave is reset on the same reset.

Structure
REQ-029 axil_req_t and axil_rsp_t, built from AXI4L_CONF_* widths, SHALL live in the shared soc_config_pkg or a companion axil_pkg.
REQ-030 The FSM state enums SHALL be local to the module.
REQ-031 One sub-module, rr_arb2 (2-way round-robin grant with a last-grant register and an update strobe), SHALL be instantiated twice, once for read and once for write.

Verification
REQ-032 Only m0 reads 0x3000_0000, slave returns 0xDEAD_BEEF/OKAY -> s arvalid rises 1 cycle after m0 arvalid; m0 gets 0xDEAD_BEEF; m1 rvalid stays 0.
REQ-033 m0 and m1 arvalid in the same cycle after reset (0x3000_0000 and 0x3000_0004) -> m0 is served first, then m1; a repeated tie next serves m1 first.
REQ-034 m1 writes 0x1234_5678 (strb 0xF) to 0x3000_0010 with wvalid 3 cycles after awvalid -> s awvalid drops after the aw handshake; WR_RESP is entered only after w; m1 gets bresp OKAY.
REQ-035 m0 write and m1 read are issued simultaneously -> both reach s concurrently and both complete with correct routing.
REQ-036 Slave returns SLVERR on a read -> rresp 2'b10 reaches the granted master unchanged.
REQ-037 rst_i is pulsed in RD_DATA before rvalid -> all outputs are 0 next cycle; a new m1 read then completes normally.
